dotprod_operand_feeder: RTL and testbench
=========================================

Name: dotprod_operand_feeder

Overview:
- Upstream operand stage for the dotprod core.
- Holds two local vectors, A and B, which a host or loader writes word by word.
- On start, streams element pairs (A[i], B[i]) for i = 0..len-1 over a valid/ready interface into the multiply-accumulate datapath.
- Pulses done after the last pair is accepted, so the core can sample its accumulated return_val.

Parameters:
- DATA_W, 32, width of each vector element and of out_a/out_b.
- DEPTH, 16, number of entries in each of A and B.
- ADDR_W, 4, write-address width; DEPTH must equal 2**ADDR_W.

Ports:
- sys_clk  in  1  single clock; all logic rising-edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe for the vector buffers.
- wr_sel  in  1  buffer select: 0 = A, 1 = B.
- wr_addr  in  ADDR_W  element index to write.
- wr_data  in  DATA_W  element value.
- start  in  1  single-cycle request to begin streaming.
- n  in  32  requested element count; sampled on an accepted start.
- out_valid  out  1  a pair is presented.
- out_ready  in  1  downstream accepts the pair.
- out_a  out  DATA_W  A[idx].
- out_b  out  DATA_W  B[idx].
- out_last  out  1  the current pair is the final one.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- len_err  out  1  n exceeded DEPTH on the last start.

Behaviour:
- Reset values: out_valid, out_a, out_b, out_last, busy, done and len_err are all 0; the FSM is in IDLE.
- Vector storage is not reset; its contents are undefined until written.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - wr_en writes wr_data into the selected buffer at wr_addr, visible from the next cycle.
  - start=1 is accepted. It latches len = min(n, DEPTH), sets len_err = (n > DEPTH), sets idx = 0 and busy = 1.
  - If len == 0: go to FIN and emit no beats.
  - If len > 0: go to RUN. out_valid rises in the cycle after start (latency 1), with out_a = A[0] and out_b = B[0].
- RUN, handshake rules:
  - A beat transfers on any edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_a, out_b and out_last hold stable.
  - out_valid never drops mid-stream without a transfer.
  - On a transfer with idx < len-1: idx increments and the next pair appears on the following cycle. Back-to-back beats run at one per cycle when out_ready stays high.
  - out_last = (idx == len-1).
  - A transfer with out_last=1 clears out_valid and out_last and moves to FIN.
- FIN: done = 1 for exactly one cycle, busy clears in the same cycle, then return to IDLE.
- Protection: wr_en is ignored while busy. start is ignored while busy.
- len_err holds until the next accepted start.
- Widths: idx is ADDR_W+1 bits and never wraps. Clamping of n is done in the full 32-bit width.
- Asynchronous reset mid-stream aborts immediately with outputs at their reset values and no done pulse. Buffer contents are unspecified after reset.

Optional Feature:
- Macro: FEEDER_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0], which counts cycles in RUN with out_valid=1 and out_ready=0.
  - It clears on an accepted start and saturates at 16'hFFFF.
  - It holds its value after done, for throughput profiling of the core.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic stream: write A = 1,2,3,4 and B = 5,6,7,8; start with n = 4; out_ready held at 1.
  - Four consecutive beats: (1,5), (2,6), (3,7), (4,8).
  - out_last on the 4th beat only; done one cycle after it; len_err = 0.
- Backpressure: same data; out_ready toggles 1,0,0,1,…
  - Pairs stay stable while stalled; exactly 4 transfers in order.
  - With the macro: stall_cnt equals the number of stalled valid cycles.
- Zero length: start with n = 0.
  - out_valid never rises.
  - done pulses exactly 2 cycles after start; busy is high for 1 cycle.
- Overlength: fill 16 entries; start with n = 20.
  - Exactly 16 beats, out_last on idx 15.
  - len_err = 1 and stays high until the next start with n = 3, which clears it.
- Protection: during RUN, pulse start with n = 2 and write A[0] = 99.
  - The original stream completes unchanged.
  - A[0] still holds its old value on the next run.
- Reset mid-run: drop sys_rst_n after 2 beats.
  - All outputs go to 0 asynchronously; no done pulse.
  - After reload, a new start with n = 4 streams normally.

Source files
------------

// File: rtl/dotprod_operand_feeder.sv
// dotprod_operand_feeder: holds operand vectors A and B and streams (A[i], B[i])
// pairs to the multiply-accumulate datapath over a valid/ready interface.
// Optional build macro FEEDER_STALL_CNT_EN adds a saturating stall_cnt output
// that counts backpressured cycles of the most recent stream.
module dotprod_operand_feeder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [31:0]       n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_last,
    output logic              busy,
    output logic              done,
`ifdef FEEDER_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              len_err
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              len_err_q, len_err_d;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]       stall_q, stall_d;
`endif

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic              mem_we_c;
    logic [IDX_W-1:0]  len_clamp_c;
    logic [IDX_W-1:0]  idx_nxt_c;

    // Clamp the requested count in the full 32-bit width before narrowing.
    assign len_clamp_c = (n > 32'(DEPTH)) ? IDX_W'(DEPTH) : n[IDX_W-1:0];
    assign idx_nxt_c   = idx_q + IDX_W'(1);

    // Operand buffers; deliberately not reset.
    always_ff @(posedge sys_clk) begin
        if (mem_we_c) begin
            if (wr_sel) mem_b[wr_addr] <= wr_data;
            else        mem_a[wr_addr] <= wr_data;
        end
    end

    // Next-state and output logic for the streaming FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        len_err_d = len_err_q;
        mem_we_c  = 1'b0;
`ifdef FEEDER_STALL_CNT_EN
        stall_d   = stall_q;
`endif
        case (state_q)
            IDLE: begin
                mem_we_c = wr_en && !busy_q;
                if (start && !busy_q) begin
                    len_d     = len_clamp_c;
                    len_err_d = (n > 32'(DEPTH));
                    idx_d     = '0;
                    busy_d    = 1'b1;
`ifdef FEEDER_STALL_CNT_EN
                    stall_d   = '0;
`endif
                    if (len_clamp_c == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                        valid_d = 1'b1;
                        a_d     = mem_a[ADDR_ZERO];
                        b_d     = mem_b[ADDR_ZERO];
                        last_d  = (len_clamp_c == IDX_W'(1));
                    end
                end
            end
            RUN: begin
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        idx_d  = idx_nxt_c;
                        a_d    = mem_a[idx_nxt_c[ADDR_W-1:0]];
                        b_d    = mem_b[idx_nxt_c[ADDR_W-1:0]];
                        last_d = (idx_nxt_c == (len_q - IDX_W'(1)));
                    end
                end
`ifdef FEEDER_STALL_CNT_EN
                if (valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
                    stall_d = stall_q + 16'd1;
                end
`endif
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
`ifdef FEEDER_STALL_CNT_EN
            stall_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
`ifdef FEEDER_STALL_CNT_EN
            stall_q   <= stall_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign len_err   = len_err_q;
`ifdef FEEDER_STALL_CNT_EN
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dotprod_operand_feeder.sv
// Testbench for dotprod_operand_feeder: randomized data and backpressure
// checked against a vector model of A/B and the min(n, DEPTH) stream rule.
module tb_dotprod_operand_feeder;

    localparam int DEPTH  = 16;
    localparam int BUDGET = 200;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        wr_en, wr_sel, start, out_ready;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data, n;
    logic        out_valid, out_last, busy, done, len_err;
    logic [31:0] out_a, out_b;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference vectors as the host believes them to be.
    logic [31:0] ref_a [DEPTH];
    logic [31:0] ref_b [DEPTH];

    // Observations from the most recent stream.
    logic [31:0] got_a [$];
    logic [31:0] got_b [$];
    logic        got_last [$];
    int first_cyc, last_cyc, done_cyc, busy_cycles, stalls, unstable;
    bit valid_seen, timed_out, done_after;

    dotprod_operand_feeder dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
`ifdef FEEDER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .len_err   (len_err)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int exp_len(input logic [31:0] nreq);
        return (nreq > 32'(DEPTH)) ? DEPTH : int'(nreq);
    endfunction

    task automatic wr(input bit sel, input int addr, input logic [31:0] d, input bit upd);
        @(negedge sys_clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = d;
        @(negedge sys_clk);
        wr_en = 1'b0;
        if (upd) begin
            if (sel) ref_b[addr] = d;
            else     ref_a[addr] = d;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b0, i, $urandom, 1'b1);
            wr(1'b1, i, $urandom, 1'b1);
        end
    endtask

    // Start a stream and record beats; mode 0 = ready high, 1 = 1,0,0,1 pattern, 2 = random.
    task automatic stream(input logic [31:0] nreq, input int mode, input bit inject);
        bit rdy, pv, pr, pl;
        logic [31:0] pa, pb;
        got_a.delete(); got_b.delete(); got_last.delete();
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        busy_cycles = 0; stalls = 0; unstable = 0;
        valid_seen = 0; timed_out = 0; done_after = 0;
        pv = 0; pr = 0; pl = 0; pa = '0; pb = '0;
        @(negedge sys_clk);
        start = 1'b1; n = nreq; out_ready = 1'b0;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge sys_clk);
            start = 1'b0; wr_en = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy) busy_cycles++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (pv && !pr) begin
                if (!out_valid || out_a !== pa || out_b !== pb || out_last !== pl) unstable++;
            end
            if (out_valid) begin
                valid_seen = 1;
                if (rdy) begin
                    got_a.push_back(out_a); got_b.push_back(out_b); got_last.push_back(out_last);
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end else begin
                    stalls++;
                end
            end
            pv = out_valid; pr = rdy; pa = out_a; pb = out_b; pl = out_last;
            out_ready = rdy;
            if (inject && cyc == 2) begin
                start = 1'b1; n = 32'd2;
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 32'd99;
            end
        end
        if (done_cyc < 0) timed_out = 1;
        else begin
            @(negedge sys_clk);
            done_after = done;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        total++;
        if ({out_valid, out_a, out_b, out_last, busy, done, len_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b a=%h b=%h last=%b busy=%b done=%b len_err=%b, expected all 0",
                     out_valid, out_a, out_b, out_last, busy, done, len_err);
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, i, 32'(i + 1), 1'b1);
            wr(1'b1, i, 32'(i + 5), 1'b1);
        end
        stream(32'd4, 0, 1'b0);
        total++;
        if (timed_out || got_a.size() != 4) begin
            bad++; $display("FAIL basic_count: got %0d beats (timeout=%0d), expected 4", got_a.size(), timed_out);
        end
        for (int i = 0; i < got_a.size() && i < 4; i++) begin
            total++;
            if (got_a[i] !== ref_a[i] || got_b[i] !== ref_b[i] || got_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL basic_beat%0d: got (%0d,%0d,last=%b), expected (%0d,%0d,last=%b)",
                         i, got_a[i], got_b[i], got_last[i], ref_a[i], ref_b[i], i == 3);
            end
        end
        total++;
        if (first_cyc != 1 || last_cyc != 4) begin
            bad++; $display("FAIL basic_timing: first=%0d last=%0d, expected 1 and 4", first_cyc, last_cyc);
        end
        total++;
        if (done_cyc != last_cyc + 2 || done_after !== 1'b0 || busy_cycles != done_cyc - 1) begin
            bad++;
            $display("FAIL basic_done: done_cyc=%0d after=%b busy_cycles=%0d, expected done_cyc=%0d after=0 busy=%0d",
                     done_cyc, done_after, busy_cycles, last_cyc + 2, last_cyc + 1);
        end
        total++;
        if (len_err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_flags: len_err=%b busy=%b, expected 0 0", len_err, busy);
        end
    endtask

    task automatic test_backpressure();
        stream(32'd4, 1, 1'b0);
        total++;
        if (timed_out || got_a.size() != 4) begin
            bad++; $display("FAIL bp_count: got %0d beats (timeout=%0d), expected 4", got_a.size(), timed_out);
        end
        for (int i = 0; i < got_a.size() && i < 4; i++) begin
            total++;
            if (got_a[i] !== ref_a[i] || got_b[i] !== ref_b[i] || got_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL bp_beat%0d: got (%0d,%0d,last=%b), expected (%0d,%0d,last=%b)",
                         i, got_a[i], got_b[i], got_last[i], ref_a[i], ref_b[i], i == 3);
            end
        end
        total++;
        if (unstable != 0 || stalls == 0) begin
            bad++; $display("FAIL bp_stable: unstable=%0d stalls=%0d, expected 0 and nonzero", unstable, stalls);
        end
`ifdef FEEDER_STALL_CNT_EN
        total++;
        if (stall_cnt !== 16'(stalls)) begin
            bad++; $display("FAIL bp_stall_cnt: got %0d, expected %0d", stall_cnt, stalls);
        end
`endif
    endtask

    task automatic test_zero_len();
        stream(32'd0, 0, 1'b0);
        total++;
        if (timed_out || valid_seen || done_cyc != 2 || busy_cycles != 1 || done_after !== 1'b0) begin
            bad++;
            $display("FAIL zero_len: valid_seen=%0d done_cyc=%0d busy_cycles=%0d after=%b, expected 0 2 1 0",
                     valid_seen, done_cyc, busy_cycles, done_after);
        end
        total++;
        if (len_err !== 1'b0) begin
            bad++; $display("FAIL zero_len_err: got %b, expected 0", len_err);
        end
    endtask

    task automatic test_overlength();
        int el;
        fill_random();
        stream(32'd20, 2, 1'b0);
        el = exp_len(32'd20);
        total++;
        if (timed_out || got_a.size() != el) begin
            bad++; $display("FAIL over_count: got %0d beats (timeout=%0d), expected %0d", got_a.size(), timed_out, el);
        end
        for (int i = 0; i < got_a.size() && i < el; i++) begin
            total++;
            if (got_a[i] !== ref_a[i] || got_b[i] !== ref_b[i] || got_last[i] !== (i == el - 1)) begin
                bad++;
                $display("FAIL over_beat%0d: got (%h,%h,last=%b), expected (%h,%h,last=%b)",
                         i, got_a[i], got_b[i], got_last[i], ref_a[i], ref_b[i], i == el - 1);
            end
        end
        total++;
        if (unstable != 0) begin
            bad++; $display("FAIL over_stable: unstable=%0d, expected 0", unstable);
        end
        repeat (3) @(negedge sys_clk);
        total++;
        if (len_err !== 1'b1) begin
            bad++; $display("FAIL over_len_err: got %b, expected 1", len_err);
        end
        stream(32'd3, 0, 1'b0);
        total++;
        if (timed_out || got_a.size() != 3 || len_err !== 1'b0) begin
            bad++; $display("FAIL over_clear: beats=%0d len_err=%b, expected 3 and 0", got_a.size(), len_err);
        end
    endtask

    task automatic test_random();
        logic [31:0] nreq;
        int el;
        for (int r = 0; r < 4; r++) begin
            fill_random();
            nreq = (r == 3) ? 32'hFFFF_FFF0 : 32'($urandom_range(1, 20));
            stream(nreq, 2, 1'b0);
            el = exp_len(nreq);
            total++;
            if (timed_out || got_a.size() != el || unstable != 0 || done_cyc != last_cyc + 2) begin
                bad++;
                $display("FAIL rand%0d_stream: n=%0d beats=%0d unstable=%0d done_cyc=%0d last=%0d, expected %0d beats",
                         r, nreq, got_a.size(), unstable, done_cyc, last_cyc, el);
            end
            for (int i = 0; i < got_a.size() && i < el; i++) begin
                total++;
                if (got_a[i] !== ref_a[i] || got_b[i] !== ref_b[i] || got_last[i] !== (i == el - 1)) begin
                    bad++;
                    $display("FAIL rand%0d_beat%0d: got (%h,%h,last=%b), expected (%h,%h,last=%b)",
                             r, i, got_a[i], got_b[i], got_last[i], ref_a[i], ref_b[i], i == el - 1);
                end
            end
            total++;
            if (len_err !== (nreq > 32'(DEPTH))) begin
                bad++; $display("FAIL rand%0d_len_err: got %b, expected %b", r, len_err, nreq > 32'(DEPTH));
            end
`ifdef FEEDER_STALL_CNT_EN
            total++;
            if (stall_cnt !== 16'(stalls)) begin
                bad++; $display("FAIL rand%0d_stall_cnt: got %0d, expected %0d", r, stall_cnt, stalls);
            end
`endif
        end
    endtask

    task automatic test_protection();
        int errs;
        fill_random();
        stream(32'd6, 0, 1'b1);
        errs = 0;
        for (int i = 0; i < got_a.size() && i < 6; i++)
            if (got_a[i] !== ref_a[i] || got_b[i] !== ref_b[i] || got_last[i] !== (i == 5)) errs++;
        total++;
        if (timed_out || got_a.size() != 6 || errs != 0) begin
            bad++; $display("FAIL prot_stream: beats=%0d bad_beats=%0d, expected 6 and 0", got_a.size(), errs);
        end
        stream(32'd1, 0, 1'b0);
        total++;
        if (got_a.size() != 1 || got_a[0] !== ref_a[0]) begin
            bad++;
            $display("FAIL prot_a0: beats=%0d a0=%h, expected 1 beat with %h", got_a.size(),
                     (got_a.size() > 0) ? got_a[0] : 32'hx, ref_a[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        bit done_seen;
        @(negedge sys_clk);
        start = 1'b1; n = 32'd4; out_ready = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (2) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_a, out_b, out_last, busy, done, len_err} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: valid=%b a=%h b=%h last=%b busy=%b done=%b len_err=%b, expected all 0",
                     out_valid, out_a, out_b, out_last, busy, done, len_err);
        end
        done_seen = 0;
        repeat (3) begin
            @(negedge sys_clk);
            if (done || out_valid) done_seen = 1;
        end
        sys_rst_n = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            if (done || out_valid) done_seen = 1;
        end
        out_ready = 1'b0;
        total++;
        if (done_seen) begin
            bad++; $display("FAIL midrst_no_done: got done/valid activity, expected none");
        end
        fill_random();
        stream(32'd4, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_a.size() <= i || got_a[i] !== ref_a[i] || got_b[i] !== ref_b[i] || got_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL midrst_beat%0d: beats=%0d, expected (%h,%h)", i, got_a.size(), ref_a[i], ref_b[i]);
            end
        end
    endtask

    initial begin
        wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0;
        start = 0; n = '0; out_ready = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_overlength();
        test_random();
        test_protection();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
